// File: rtl/simple_dma_controller_if.sv
// Device-side and memory-side signal bundle for simple_dma_controller.
// master = controller view, slave = device/memory environment view.
interface simple_dma_controller_if;
  logic        dma_rqst;
  logic        dma_rd_wr;
  logic [15:0] dma_start_address;
  logic [15:0] dma_num_words;
  logic        dev_ack;
  logic [15:0] dev_out;
  logic [15:0] dev_in;
  logic        dma_ack;
  logic        dma_end_flag;
  logic        dma_error;
  logic [14:0] dma_addr;
  logic [15:0] dma_din;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic        dma_priority;
  logic [15:0] dma_dout;
  logic        dma_ready;
  logic        dma_resp;

  modport master (
    input  dma_rqst, dma_rd_wr, dma_start_address, dma_num_words,
    input  dev_ack, dev_out, dma_dout, dma_ready, dma_resp,
    output dev_in, dma_ack, dma_end_flag, dma_error,
    output dma_addr, dma_din, dma_en, dma_we, dma_priority
  );

  modport slave (
    output dma_rqst, dma_rd_wr, dma_start_address, dma_num_words,
    output dev_ack, dev_out, dma_dout, dma_ready, dma_resp,
    input  dev_in, dma_ack, dma_end_flag, dma_error,
    input  dma_addr, dma_din, dma_en, dma_we, dma_priority
  );
endinterface

// File: rtl/simple_dma_controller.sv
// Single-channel word DMA between a handshaking device and a 16-bit memory port.
// One word at a time: wait for device, one memory access, optional read-capture cycle.
module simple_dma_controller #(
  parameter logic        DMA_PRIORITY = 1'b0,
  parameter logic [15:0] ADDR_STEP    = 16'd2
) (
  input logic                     clk,
  input logic                     reset_n,
  simple_dma_controller_if.master bus
);

  typedef enum logic [2:0] {IDLE, WAIT_DEV, MEM_ACC, RD_CAP, DONE, ERR} state_t;

  state_t      state;
  state_t      after_word;
  logic [15:0] addr;
  logic [15:0] count;
  logic [15:0] count_next;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        dir;
  logic        en;
  logic        ack;
  logic        end_flag;
  logic        error;
  logic [1:0]  we;

  assign count_next = count - 16'd1;

  // A dropped request abandons the operation without an end flag once the word finishes.
  always_comb begin
    after_word = WAIT_DEV;
    if (!bus.dma_rqst)
      after_word = IDLE;
    else if (count_next == '0)
      after_word = DONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr     <= '0;
      count    <= '0;
      dir      <= 1'b0;
      wdata    <= '0;
      rdata    <= '0;
      en       <= 1'b0;
      we       <= '0;
      ack      <= 1'b0;
      end_flag <= 1'b0;
      error    <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.dma_rqst) begin
            addr  <= bus.dma_start_address;
            count <= bus.dma_num_words;
            dir   <= bus.dma_rd_wr;
            if (bus.dma_num_words != '0) begin
              state <= WAIT_DEV;
            end else begin
              state    <= DONE;
              end_flag <= 1'b1;
            end
          end
        end
        WAIT_DEV: begin
          if (!bus.dma_rqst) begin
            state <= IDLE;
          end else if (bus.dev_ack) begin
            if (!dir) wdata <= bus.dev_out;
            en    <= 1'b1;
            we    <= dir ? 2'b00 : 2'b11;
            state <= MEM_ACC;
          end
        end
        MEM_ACC: begin
          if (bus.dma_ready) begin
            en <= 1'b0;
            we <= '0;
            if (bus.dma_resp) begin
              state    <= ERR;
              end_flag <= 1'b1;
              error    <= 1'b1;
            end else if (dir) begin
              state <= RD_CAP;
            end else begin
              ack      <= 1'b1;
              addr     <= addr + ADDR_STEP;
              count    <= count_next;
              state    <= after_word;
              end_flag <= (after_word == DONE);
            end
          end
        end
        RD_CAP: begin
          rdata    <= bus.dma_dout;
          ack      <= 1'b1;
          addr     <= addr + ADDR_STEP;
          count    <= count_next;
          state    <= after_word;
          end_flag <= (after_word == DONE);
        end
        DONE: begin
          if (!bus.dma_rqst) begin
            state    <= IDLE;
            end_flag <= 1'b0;
          end
        end
        ERR: begin
          if (!bus.dma_rqst) begin
            state    <= IDLE;
            end_flag <= 1'b0;
            error    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dev_in       = rdata;
  assign bus.dma_ack      = ack;
  assign bus.dma_end_flag = end_flag;
  assign bus.dma_error    = error;
  assign bus.dma_addr     = addr[15:1];
  assign bus.dma_din      = wdata;
  assign bus.dma_en       = en;
  assign bus.dma_we       = we;
  assign bus.dma_priority = DMA_PRIORITY;

endmodule

// File: tb/tb_simple_dma_controller.sv
// Randomized self-checking bench for simple_dma_controller with device and memory responders.
// Expected accesses and read data are derived per operation from start address, step and word index.
module tb_simple_dma_controller;

  localparam logic        PRIO = 1'b1;
  localparam logic [15:0] STEP = 16'd2;

  typedef struct packed {
    logic [14:0] addr;
    logic [1:0]  we;
    logic [15:0] din;
  } acc_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  simple_dma_controller_if bus ();

  simple_dma_controller #(.DMA_PRIORITY(PRIO), .ADDR_STEP(STEP)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  acc_t        acc_q[$];
  logic [15:0] ack_q[$];
  int          en_len_q[$];
  int          lat_q[$];
  logic [15:0] wdata[$];
  logic [15:0] mem[int];
  logic [31:0] salt = 32'h1234_5678;
  int lat_fixed   = 0;
  int err_word    = -1;
  int acc_idx     = 0;
  int dev_idx     = 0;
  int dev_ack_pct = 70;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [14:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return ({1'b0, a} * 16'h9E37) ^ salt[15:0];
  endfunction

  // Memory responder: drives ready after a chosen latency, returns read data one cycle later.
  initial begin
    int          wait_cnt;
    int          cur_lat;
    logic        pend;
    logic [14:0] pa;
    logic [32:0] first;
    wait_cnt = 0; cur_lat = 0; pend = 1'b0; pa = '0; first = '0;
    bus.dma_ready = 1'b0;
    bus.dma_resp  = 1'b0;
    bus.dma_dout  = '0;
    forever begin
      @(negedge clk);
      bus.dma_ready = 1'b0;
      bus.dma_resp  = 1'b0;
      bus.dma_dout  = pend ? mem_word(pa) : 16'($urandom);
      pend = 1'b0;
      if (reset_n && bus.dma_en) begin
        if (wait_cnt == 0) begin
          cur_lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
          first   = {bus.dma_addr, bus.dma_we, bus.dma_din};
        end else begin
          check_eq("access_hold", 64'({bus.dma_addr, bus.dma_we, bus.dma_din}), 64'(first));
        end
        if (wait_cnt == cur_lat) begin
          bus.dma_ready = 1'b1;
          bus.dma_resp  = (acc_idx == err_word);
          acc_q.push_back({bus.dma_addr, bus.dma_we, bus.dma_din});
          lat_q.push_back(cur_lat);
          if (!bus.dma_resp && bus.dma_we == 2'b00) begin
            pend = 1'b1;
            pa   = bus.dma_addr;
          end
          acc_idx++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Device responder and output monitor.
  initial begin
    int   run;
    logic prev_ack;
    run = 0; prev_ack = 1'b0;
    bus.dev_ack = 1'b0;
    bus.dev_out = '0;
    forever begin
      @(negedge clk);
      if (bus.dma_ack) begin
        check_eq("ack_width", 64'(prev_ack), 64'(0));
        ack_q.push_back(bus.dev_in);
        dev_idx++;
      end
      prev_ack = bus.dma_ack;
      if (bus.dma_en) run++;
      else if (run > 0) begin
        en_len_q.push_back(run);
        run = 0;
      end
      bus.dev_out = (dev_idx < wdata.size()) ? wdata[dev_idx] : 16'($urandom);
      bus.dev_ack = ($urandom_range(0, 99) < dev_ack_pct);
    end
  end

  task automatic clear_env(input int lat, input int err);
    acc_q.delete(); ack_q.delete(); en_len_q.delete(); lat_q.delete();
    lat_fixed = lat; err_word = err; acc_idx = 0; dev_idx = 0;
  endtask

  task automatic run_op(input logic dir, input logic [15:0] start, input logic [15:0] n,
                        input int lat, input int err);
    int          n_acc;
    int          n_ok;
    int          cyc;
    logic [15:0] ba;
    clear_env(lat, err);
    while (wdata.size() < int'(n)) wdata.push_back(16'($urandom));
    @(negedge clk);
    bus.dma_rd_wr = dir; bus.dma_start_address = start; bus.dma_num_words = n;
    bus.dma_rqst = 1'b1;
    @(negedge clk);
    // Latched inputs must no longer matter.
    bus.dma_rd_wr = ~dir; bus.dma_start_address = 16'($urandom); bus.dma_num_words = 16'($urandom);
    if (n == '0) begin
      check_eq("zero_end_flag", 64'(bus.dma_end_flag), 64'(1));
      check_eq("zero_no_en", 64'(bus.dma_en), 64'(0));
    end
    cyc = 0;
    while (!bus.dma_end_flag && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("end_timeout", 64'(cyc < 500), 64'(1));
    @(negedge clk);
    n_acc = (err >= 0) ? err + 1 : int'(n);
    n_ok  = (err >= 0) ? err : int'(n);
    check_eq("acc_count", 64'(acc_q.size()), 64'(n_acc));
    check_eq("ack_count", 64'(ack_q.size()), 64'(n_ok));
    for (int i = 0; i < n_acc && i < acc_q.size(); i++) begin
      ba = start + 16'(i) * STEP;
      check_eq("acc_addr", 64'(acc_q[i].addr), 64'(ba[15:1]));
      check_eq("acc_we", 64'(acc_q[i].we), 64'(dir ? 2'b00 : 2'b11));
      if (!dir) check_eq("acc_din", 64'(acc_q[i].din), 64'(wdata[i]));
      if (i < en_len_q.size() && i < lat_q.size())
        check_eq("en_len", 64'(en_len_q[i]), 64'(lat_q[i] + 1));
    end
    if (dir) begin
      for (int i = 0; i < n_ok && i < ack_q.size(); i++) begin
        ba = start + 16'(i) * STEP;
        check_eq("dev_in", 64'(ack_q[i]), 64'(mem_word(ba[15:1])));
      end
    end
    check_eq("end_flag", 64'(bus.dma_end_flag), 64'(1));
    check_eq("error_flag", 64'(bus.dma_error), 64'(err >= 0));
    bus.dma_rqst = 1'b0;
    @(negedge clk);
    check_eq("end_clear", 64'(bus.dma_end_flag), 64'(0));
    check_eq("error_clear", 64'(bus.dma_error), 64'(0));
    check_eq("idle_no_en", 64'(bus.dma_en), 64'(0));
    wdata.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, 64'({bus.dev_in, bus.dma_ack, bus.dma_end_flag, bus.dma_error,
                       bus.dma_addr, bus.dma_din, bus.dma_en, bus.dma_we}), 64'(0));
    check_eq({tag, "_prio"}, 64'(bus.dma_priority), 64'(PRIO));
  endtask

  initial begin
    int   cyc;
    logic seen;
    logic        r_dir;
    logic [15:0] r_start;
    logic [15:0] r_n;
    int          r_lat;
    int          r_err;

    bus.dma_rqst = 1'b0; bus.dma_rd_wr = 1'b0;
    bus.dma_start_address = '0; bus.dma_num_words = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    reset_n = 1'b1;
    clear_env(0, -1);
    repeat (5) @(negedge clk);
    check_eq("post_reset_no_access", 64'(acc_q.size()), 64'(0));

    // Three-word write to 0x0200.
    wdata = '{16'h1111, 16'h2222, 16'h3333};
    run_op(1'b0, 16'h0200, 16'd3, 0, -1);

    // Two-word read at 0x0300 with ready delayed three cycles.
    mem[int'(15'h180)] = 16'hBEEF;
    mem[int'(15'h181)] = 16'hCAFE;
    run_op(1'b1, 16'h0300, 16'd2, 3, -1);

    run_op(1'b0, 16'h1234, 16'd0, 0, -1);
    run_op(1'b0, 16'hFFFE, 16'd2, 1, -1);
    run_op(1'b1, 16'hFFFE, 16'd2, 0, -1);
    run_op(1'b0, 16'h0040, 16'd4, 0, 1);
    run_op(1'b1, 16'h0100, 16'd4, 2, 1);

    // Request dropped while a memory access is outstanding.
    clear_env(3, -1);
    repeat (3) wdata.push_back(16'($urandom));
    @(negedge clk);
    bus.dma_rd_wr = 1'b0; bus.dma_start_address = 16'h0500; bus.dma_num_words = 16'd3;
    bus.dma_rqst = 1'b1;
    cyc = 0;
    while (!bus.dma_en && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("drop_en_timeout", 64'(cyc < 100), 64'(1));
    bus.dma_rqst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= bus.dma_end_flag;
    end
    check_eq("drop_no_end", 64'(seen), 64'(0));
    check_eq("drop_acc_count", 64'(acc_q.size()), 64'(1));
    check_eq("drop_ack_count", 64'(ack_q.size()), 64'(1));
    check_eq("drop_en_len", 64'(en_len_q.size() > 0 ? en_len_q[0] : 0), 64'(4));
    wdata.delete();

    // Request dropped while waiting on the device.
    clear_env(0, -1);
    dev_ack_pct = 0;
    @(negedge clk);
    bus.dma_rd_wr = 1'b1; bus.dma_start_address = 16'h0600; bus.dma_num_words = 16'd2;
    bus.dma_rqst = 1'b1;
    repeat (3) @(negedge clk);
    bus.dma_rqst = 1'b0;
    dev_ack_pct = 70;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= bus.dma_end_flag | bus.dma_en;
    end
    check_eq("waitdev_drop_quiet", 64'(seen), 64'(0));
    check_eq("waitdev_drop_acc", 64'(acc_q.size()), 64'(0));

    // Reset asserted in the middle of an access.
    clear_env(3, -1);
    @(negedge clk);
    bus.dma_rd_wr = 1'b1; bus.dma_start_address = 16'h0700; bus.dma_num_words = 16'd2;
    bus.dma_rqst = 1'b1;
    cyc = 0;
    while (!bus.dma_en && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_en_timeout", 64'(cyc < 100), 64'(1));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset_outputs");
    bus.dma_rqst = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_env(0, -1);
    repeat (10) @(negedge clk);
    check_eq("midreset_no_access", 64'(acc_q.size()), 64'(0));

    // Randomized operations.
    for (int k = 0; k < 25; k++) begin
      salt    = $urandom;
      r_dir   = 1'($urandom_range(0, 1));
      r_start = 16'($urandom);
      r_n     = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      r_lat   = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 3));
      r_err   = (r_n != '0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(r_n) - 1)) : -1;
      run_op(r_dir, r_start, r_n, r_lat, r_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
